// File: rtl/ccu_muldiv_seq.sv
// Multi-cycle RV32M sequencer for the slow CCU path: fixed-latency multiplier,
// restoring divider, and the stall/done handshake toward the EX stage.
module ccu_muldiv_seq #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2,
    parameter int CNT_W   = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       alu_mode,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             flush,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ccu_ans_mux_sel,
    output logic [1:0]       state_dbg
);

    // Handshake: an op is taken in IDLE when start & is_md & ~flush; stall stays
    // high until the DONE cycle, where done=1 for exactly one cycle and stall=0
    // so the pipeline advances once and the next instruction meets IDLE.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [2:0]         op_r;
    logic [WIDTH-1:0]   quo_r;
    logic [WIDTH-1:0]   rem_r;
    logic [WIDTH-1:0]   dvs_r;
    logic [2*WIDTH-1:0] prod_r;

    logic               is_md;
    logic               accept;
    logic               in_signed;
    logic               div_zero;
    logic               div_ovf;
    logic               special;
    logic [WIDTH-1:0]   special_res;
    logic [WIDTH-1:0]   abs1;
    logic [WIDTH-1:0]   abs2;

    assign is_md     = (alu_mode[7:4] == 4'h4);
    assign accept    = (state == S_IDLE) & start & is_md & ~flush;
    assign in_signed = ~alu_mode[0];
    assign div_zero  = (src2 == '0);
    assign div_ovf   = in_signed & (src1 == INT_MIN) & (src2 == '1);
    assign special   = alu_mode[2] & (div_zero | div_ovf);
    assign abs1      = (in_signed & src1[WIDTH-1]) ? (-src1) : src1;
    assign abs2      = (in_signed & src2[WIDTH-1]) ? (-src2) : src2;

    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = alu_mode[1] ? src1 : '1;
        else
            special_res = alu_mode[1] ? '0 : INT_MIN;
    end

    // Multiplier: operands as (WIDTH+1)-bit values whose top bit carries the
    // sign for the signed forms, then sign-extended to the full product width.
    logic               a_sext;
    logic               b_sext;
    logic [WIDTH:0]     a_sx;
    logic [WIDTH:0]     b_sx;
    logic [2*WIDTH-1:0] prod_c;
    logic [2*WIDTH-1:0] prod_sel;
    logic [WIDTH-1:0]   mul_res;

    assign a_sext   = ((op_r[1:0] == 2'd1) | (op_r[1:0] == 2'd2)) & a_r[WIDTH-1];
    assign b_sext   = (op_r[1:0] == 2'd1) & b_r[WIDTH-1];
    assign a_sx     = {a_sext, a_r};
    assign b_sx     = {b_sext, b_r};
    assign prod_c   = {{(WIDTH-1){a_sx[WIDTH]}}, a_sx} * {{(WIDTH-1){b_sx[WIDTH]}}, b_sx};
    assign prod_sel = (MUL_LAT == 1) ? prod_c : prod_r;
    assign mul_res  = (op_r[1:0] == 2'd0) ? prod_sel[WIDTH-1:0] : prod_sel[2*WIDTH-1:WIDTH];

    // Restoring divider step: shift one dividend bit into the partial remainder
    // and keep the subtraction only when it does not go negative.
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic               ge;
    logic [WIDTH-1:0]   rem_n;
    logic [WIDTH-1:0]   quo_n;
    logic               neg_q;
    logic               neg_r;
    logic [WIDTH-1:0]   div_res;
    logic [WIDTH-1:0]   fin_res;

    assign shifted = {rem_r, quo_r[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs_r};
    assign ge      = ~diff[WIDTH];
    assign rem_n   = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_n   = {quo_r[WIDTH-2:0], ge};
    assign neg_q   = ~op_r[0] & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
    assign neg_r   = ~op_r[0] & a_r[WIDTH-1];
    assign div_res = op_r[1] ? (neg_r ? (-rem_n) : rem_n)
                             : (neg_q ? (-quo_n) : quo_n);
    assign fin_res = op_r[2] ? div_res : mul_res;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            a_r    <= '0;
            b_r    <= '0;
            op_r   <= '0;
            quo_r  <= '0;
            rem_r  <= '0;
            dvs_r  <= '0;
            prod_r <= '0;
            result <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        a_r   <= src1;
                        b_r   <= src2;
                        op_r  <= alu_mode[2:0];
                        cnt   <= '0;
                        quo_r <= abs1;
                        rem_r <= '0;
                        dvs_r <= abs2;
                        if (!alu_mode[2]) begin
                            state <= S_MUL;
                        end else if (special) begin
                            result <= special_res;
                            state  <= S_DONE;
                        end else begin
                            state <= S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        prod_r <= prod_c;
                        cnt    <= cnt + 1'b1;
                        if (cnt == CNT_W'(MUL_LAT - 1)) begin
                            result <= fin_res;
                            state  <= S_DONE;
                        end
                    end
                end
                S_DIV: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        rem_r <= rem_n;
                        quo_r <= quo_n;
                        cnt   <= cnt + 1'b1;
                        if (cnt == CNT_W'(WIDTH - 1)) begin
                            result <= fin_res;
                            state  <= S_DONE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign stall           = accept | (state == S_MUL) | (state == S_DIV);
    assign done            = (state == S_DONE);
    assign ccu_ans_mux_sel = done;
    assign state_dbg       = state;

endmodule

// File: tb/tb_ccu_muldiv_seq.sv
// Scoreboarded bench for ccu_muldiv_seq: directed RV32M vectors, random ops,
// flush, mid-operation reset, non-M modes and back-to-back issue.
module tb_ccu_muldiv_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  alu_mode;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] result;
    logic        ccu_ans_mux_sel;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];
    int          lat_q[$];
    logic [31:0] last_res = '0;

    ccu_muldiv_seq #(.WIDTH(32), .MUL_LAT(2), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .alu_mode(alu_mode),
        .src1(src1), .src2(src2), .flush(flush), .stall(stall),
        .done(done), .result(result), .ccu_ans_mux_sel(ccu_ans_mux_sel),
        .state_dbg(state_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [7:0] m, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ub;
        logic [63:0] p;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'({32'b0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (m[2:0])
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int lat_model(input logic [7:0] m, input logic [31:0] a, input logic [31:0] b);
        if (!m[2]) return 3;
        if (b == 0) return 1;
        if (!m[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Called #1 after a rising edge; returns #1 after the edge that ends the done cycle.
    task automatic issue(input logic [7:0] m, input logic [31:0] a, input logic [31:0] b, input bit keep);
        bit          got;
        int          cyc;
        logic [31:0] e;
        int          l;
        start    = 1'b1;
        alu_mode = m;
        src1     = a;
        src2     = b;
        exp_q.push_back(model(m, a, b));
        lat_q.push_back(lat_model(m, a, b));
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 100) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                e   = exp_q.pop_front();
                l   = lat_q.pop_front();
                check("done_cycle", 32'(cyc), 32'(l));
                check("result", result, e);
                check("mux_sel", {31'b0, ccu_ans_mux_sel}, 32'd1);
                check("stall_in_done", {31'b0, stall}, 32'd0);
                last_res = e;
            end else begin
                check("stall_busy", {31'b0, stall}, 32'd1);
                cyc++;
            end
            @(posedge clk);
            #1;
        end
        if (!got) begin
            check("done_timeout", 32'd0, 32'd1);
            void'(exp_q.pop_front());
            void'(lat_q.pop_front());
        end
        if (!keep) start = 1'b0;
    endtask

    logic [7:0]  d_mode[16] = '{8'h40, 8'h43, 8'h41, 8'h42, 8'h44, 8'h46, 8'h45, 8'h47,
                                 8'h45, 8'h46, 8'h44, 8'h46, 8'h40, 8'h41, 8'h44, 8'h47};
    logic [31:0] d_a[16]    = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100,
                                 32'd5, 32'd5, 32'h80000000, 32'h80000000,
                                 32'h80000000, 32'h80000000, 32'd7, 32'hFFFFFFF0};
    logic [31:0] d_b[16]    = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2,
                                 32'd2, 32'd2, 32'd7, 32'd7,
                                 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                 32'h80000000, 32'h80000000, 32'hFFFFFFFE, 32'd3};

    initial begin
        int dn;
        rst = 1'b1; start = 1'b0; flush = 1'b0;
        alu_mode = '0; src1 = '0; src2 = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_mux", {31'b0, ccu_ans_mux_sel}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_state", {30'b0, state_dbg}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) issue(d_mode[i], d_a[i], d_b[i], 1'b0);

        for (int i = 0; i < 16; i++) begin
            logic [31:0] rb;
            rb = $urandom;
            case ($urandom_range(0, 3))
                0: rb = '0;
                1: rb = 32'($urandom_range(1, 9));
                default: ;
            endcase
            issue(8'h40 + 8'($urandom_range(0, 7)), $urandom, rb, 1'b0);
        end

        // Flush during cycle 10 of a division.
        start = 1'b1; alu_mode = 8'h44; src1 = 32'd1000; src2 = 32'd3;
        repeat (10) begin @(posedge clk); #1; end
        flush = 1'b1; start = 1'b0;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        check("flush_state", {30'b0, state_dbg}, 32'd0);
        check("flush_stall", {31'b0, stall}, 32'd0);
        dn = 0;
        repeat (40) begin @(negedge clk); if (done) dn++; end
        check("flush_no_done", 32'(dn), 32'd0);
        check("flush_result_kept", result, last_res);

        // Asynchronous reset in the middle of a division.
        @(posedge clk); #1;
        start = 1'b1; alu_mode = 8'h45; src1 = 32'd12345; src2 = 32'd17;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1; start = 1'b0;
        #1;
        check("midrst_stall", {31'b0, stall}, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        check("midrst_state", {30'b0, state_dbg}, 32'd0);
        check("midrst_result", result, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        // Non-M mode with start held.
        start = 1'b1; alu_mode = 8'h01; src1 = 32'd3; src2 = 32'd4;
        repeat (5) begin
            @(negedge clk);
            check("nonm_stall", {31'b0, stall}, 32'd0);
            check("nonm_done", {31'b0, done}, 32'd0);
            check("nonm_state", {30'b0, state_dbg}, 32'd0);
        end
        @(posedge clk); #1 start = 1'b0;

        // Back-to-back with start held across the handoff.
        issue(8'h40, 32'd6, 32'd7, 1'b1);
        issue(8'h45, 32'd100, 32'd7, 1'b0);
        dn = 0;
        repeat (10) begin @(negedge clk); if (done) dn++; end
        check("b2b_single_done", 32'(dn), 32'd0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
